// File: rtl/engine_cast_sequencer_pkg.sv
// Shared types for the cast sequencer: lane-ID typedefs, default sizing and the cast FSM state.
package engine_cast_sequencer_pkg;

  localparam int MASK_WIDTH_DEF      = 8;
  localparam int DATA_WIDTH_DEF      = 64;
  localparam int ID_BUNDLE_WIDTH_DEF = 4;
  localparam int ID_LANE_WIDTH_DEF   = 4;

  typedef logic [ID_BUNDLE_WIDTH_DEF-1:0] bundle_id_t;
  typedef logic [ID_LANE_WIDTH_DEF-1:0]   lane_id_t;

  typedef struct packed {
    bundle_id_t bundle;
    lane_id_t   lane;
  } lane_ids_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CAST = 1'b1
  } cast_state_e;

endpackage

// File: rtl/engine_cast_sequencer_select.sv
// Lowest-set-bit picker: one-hot of the lowest set bit of vec plus its binary index.
module onehot_lowest_select #(
  parameter int W  = 8,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec,
  output logic [W-1:0]  onehot,
  output logic [IW-1:0] index
);

  localparam logic [W-1:0] ONE = W'(1);

  always_comb begin
    onehot = vec & ~(vec - ONE);
    index  = '0;
    // Scan downward so the lowest set bit wins.
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) index = IW'(i);
    end
  end

endmodule

// File: rtl/engine_cast_sequencer.sv
// Serializes one payload into one tagged beat per set cast-mask bit, lowest lane first.
module engine_cast_sequencer
  import engine_cast_sequencer_pkg::*;
#(
  parameter int MASK_WIDTH      = MASK_WIDTH_DEF,
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int ID_BUNDLE_WIDTH = ID_BUNDLE_WIDTH_DEF,
  parameter int ID_LANE_WIDTH   = ID_LANE_WIDTH_DEF,
  localparam int RW = $clog2(MASK_WIDTH) + 1,
  localparam int IW = (MASK_WIDTH > 1) ? $clog2(MASK_WIDTH) : 1
) (
  input  logic                                  ap_clk,
  input  logic                                  areset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [DATA_WIDTH-1:0]                 in_data,
  input  logic [MASK_WIDTH-1:0]                 in_cast_mask,
  input  logic [MASK_WIDTH*ID_BUNDLE_WIDTH-1:0] cfg_ops_bundle,
  input  logic [MASK_WIDTH*ID_LANE_WIDTH-1:0]   cfg_ops_lane,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DATA_WIDTH-1:0]                 out_data,
  output logic [ID_BUNDLE_WIDTH-1:0]            out_id_bundle,
  output logic [ID_LANE_WIDTH-1:0]              out_id_lane,
  output logic [MASK_WIDTH-1:0]                 out_lane_onehot,
  output logic                                  out_last,
  output logic [RW-1:0]                         out_remaining,
  output logic [15:0]                           drop_count,
  output cast_state_e                           cast_state
);

  localparam logic [MASK_WIDTH-1:0] ONE = MASK_WIDTH'(1);

  // Handshakes: a transfer happens on a side only in a cycle where its valid and ready are both high;
  // out_valid, once raised, holds with its beat stable until out_ready takes it.
  cast_state_e           state_q, state_d;
  logic [MASK_WIDTH-1:0] pending_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [15:0]           drop_q;
  logic [MASK_WIDTH-1:0] sel;
  logic [IW-1:0]         sel_idx;
  logic [MASK_WIDTH-1:0] rest;
  logic                  is_last, hs, accept, load;

  onehot_lowest_select #(.W(MASK_WIDTH), .IW(IW)) u_select (
    .vec    (pending_q),
    .onehot (sel),
    .index  (sel_idx)
  );

  assign rest    = pending_q & (pending_q - ONE);
  assign is_last = (rest == '0);
  assign hs      = out_valid & out_ready;
  assign accept  = in_valid & in_ready;
  assign load    = accept & (in_cast_mask != '0);

  always_ff @(posedge ap_clk) begin
    if (areset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (load) state_d = ST_CAST;
      ST_CAST: if (hs && is_last) state_d = load ? ST_CAST : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid     = (state_q == ST_CAST);
    in_ready      = ~areset & ((state_q == ST_IDLE) | (out_valid & out_ready & is_last));
    out_last      = out_valid & is_last;
    out_id_bundle = '0;
    out_id_lane   = '0;
    if (out_valid) begin
      out_id_bundle = cfg_ops_bundle[sel_idx*ID_BUNDLE_WIDTH +: ID_BUNDLE_WIDTH];
      out_id_lane   = cfg_ops_lane[sel_idx*ID_LANE_WIDTH +: ID_LANE_WIDTH];
    end
    out_remaining = '0;
    for (int i = 0; i < MASK_WIDTH; i++) begin
      out_remaining = out_remaining + RW'(pending_q[i]);
    end
  end

  // A same-cycle reload on the final beat overrides the clear of the finished mask.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      pending_q <= '0;
      data_q    <= '0;
      drop_q    <= '0;
    end else begin
      if (load) begin
        pending_q <= in_cast_mask;
        data_q    <= in_data;
      end else if (hs) begin
        pending_q <= rest;
      end
      if (accept && (in_cast_mask == '0) && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
    end
  end

  assign out_data        = data_q;
  assign out_lane_onehot = sel;
  assign drop_count      = drop_q;
  assign cast_state      = state_q;

endmodule

// File: tb/tb_engine_cast_sequencer.sv
// Scoreboarded bench for engine_cast_sequencer: directed cases from the block's behaviour plus random payloads.
module tb_engine_cast_sequencer;
  import engine_cast_sequencer_pkg::*;

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  bundle;
    logic [3:0]  lane;
    logic [7:0]  onehot;
    logic        last;
    logic [3:0]  remaining;
  } beat_t;
  localparam int BW = $bits(beat_t);

  logic        ap_clk = 1'b0;
  logic        areset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [7:0]  in_cast_mask;
  logic [31:0] cfg_ops_bundle;
  logic [31:0] cfg_ops_lane;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [3:0]  out_id_bundle;
  logic [3:0]  out_id_lane;
  logic [7:0]  out_lane_onehot;
  logic        out_last;
  logic [3:0]  out_remaining;
  logic [15:0] drop_count;
  cast_state_e cast_state;

  engine_cast_sequencer dut (
    .ap_clk          (ap_clk),
    .areset          (areset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_cast_mask    (in_cast_mask),
    .cfg_ops_bundle  (cfg_ops_bundle),
    .cfg_ops_lane    (cfg_ops_lane),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_id_bundle   (out_id_bundle),
    .out_id_lane     (out_id_lane),
    .out_lane_onehot (out_lane_onehot),
    .out_last        (out_last),
    .out_remaining   (out_remaining),
    .drop_count      (drop_count),
    .cast_state      (cast_state)
  );

  // ---------------- clock / reset ----------------
  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  // ---------------- model state and counters ----------------
  lane_ids_t         cfg_ids[8];
  logic [BW-1:0]     exp_q[$];
  logic [15:0]       exp_drop = 16'd0;
  int                tests = 0;
  int                fails = 0;
  int                hs_count = 0;
  int                last_hs_cyc = 0;
  int                prev_hs_cyc = 0;
  int                ready_mode = 3;
  int                pat_idx = 0;
  logic              pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      cfg_ops_bundle[i*4 +: 4] = cfg_ids[i].bundle;
      cfg_ops_lane[i*4 +: 4]   = cfg_ids[i].lane;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- out_ready driver ----------------
  initial begin
    forever begin
      @(posedge ap_clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        2: begin out_ready = pat[pat_idx % 4]; pat_idx++; end
        default: ;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    beat_t b, act;
    logic  exp_rdy;
    int    n, k;
    forever begin
      @(negedge ap_clk);
      if (areset) begin
        exp_q.delete();
        exp_drop = 16'd0;
        check("in_ready_in_reset", 128'(in_ready), 128'(0));
      end else begin
        exp_rdy = (exp_q.size() == 0) || (out_ready && exp_q.size() == 1);
        check("in_ready", 128'(in_ready), 128'(exp_rdy));
        check("out_valid", 128'(out_valid), 128'(exp_q.size() != 0));
        check("drop_count", 128'(drop_count), 128'(exp_drop));
        if (out_valid && exp_q.size() != 0) begin
          act = '{out_data, out_id_bundle, out_id_lane, out_lane_onehot, out_last, out_remaining};
          check("beat", 128'(act), 128'(exp_q[0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            hs_count++;
            prev_hs_cyc = last_hs_cyc;
            last_hs_cyc = cyc;
          end
        end
        if (in_valid && exp_rdy) begin
          if (in_cast_mask == 8'h00) begin
            if (exp_drop != 16'hFFFF) exp_drop++;
          end else begin
            n = $countones(in_cast_mask);
            k = 0;
            for (int i = 0; i < 8; i++) begin
              if (in_cast_mask[i]) begin
                b.data      = in_data;
                b.bundle    = cfg_ids[i].bundle;
                b.lane      = cfg_ids[i].lane;
                b.onehot    = 8'd1 << i;
                b.remaining = 4'(n - k);
                b.last      = ((n - k) == 1);
                exp_q.push_back(b);
                k++;
              end
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [63:0] d, input logic [7:0] m);
    int n;
    in_data      = d;
    in_cast_mask = m;
    in_valid     = 1'b1;
    n = 0;
    do begin
      @(negedge ap_clk);
      n++;
    end while (!in_ready && n < 300);
    check("send_accept", 128'(in_ready), 128'(1));
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      @(posedge ap_clk);
      #2;
      n++;
    end
    check("drain", 128'(exp_q.size() == 0 && !out_valid), 128'(1));
  endtask

  task automatic cfg_diag();
    for (int i = 0; i < 8; i++) begin
      cfg_ids[i].bundle = 4'(i);
      cfg_ids[i].lane   = 4'(7 - i);
    end
  endtask

  task automatic cfg_random();
    for (int i = 0; i < 8; i++) begin
      cfg_ids[i].bundle = 4'($urandom_range(0, 15));
      cfg_ids[i].lane   = 4'($urandom_range(0, 15));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base, n, g;
    logic [7:0] m;
    areset       = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    in_cast_mask = '0;
    out_ready    = 1'b0;
    cfg_random();
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_remaining", 128'(out_remaining), 128'(0));
    check("rst_drop", 128'(drop_count), 128'(0));
    check("rst_data", 128'(out_data), 128'(0));
    check("rst_ids", 128'({out_id_bundle, out_id_lane, out_lane_onehot}), 128'(0));
    check("rst_state", 128'(cast_state), 128'(ST_IDLE));
    areset = 1'b0;
    @(posedge ap_clk);
    #1;

    // Three-beat cast at full throughput.
    ready_mode = 0;
    base = hs_count;
    send(64'hAB, 8'b1010_0100);
    drain();
    check("mask_a4_beats", 128'(hs_count - base), 128'(3));

    // Same mask with a stalling consumer.
    ready_mode = 2;
    pat_idx = 0;
    base = hs_count;
    send(64'hAB, 8'b1010_0100);
    drain();
    check("stall_beats", 128'(hs_count - base), 128'(3));

    // Back-to-back single-lane payloads must not leave a bubble.
    ready_mode = 0;
    @(posedge ap_clk);
    #1;
    base = hs_count;
    send(64'h1111, 8'h01);
    send(64'h2222, 8'h80);
    drain();
    check("b2b_beats", 128'(hs_count - base), 128'(2));
    check("b2b_gap", 128'(last_hs_cyc - prev_hs_cyc), 128'(1));

    // All-zero masks are dropped and counted.
    repeat (3) send($urandom, 8'h00);
    drain();
    check("drop_three", 128'(drop_count), 128'(3));

    // Full mask with diagonal IDs.
    cfg_diag();
    base = hs_count;
    send({$urandom, $urandom}, 8'hFF);
    drain();
    check("full_mask_beats", 128'(hs_count - base), 128'(8));

    // Reset after the second beat of a full cast.
    ready_mode = 3;
    out_ready = 1'b1;
    base = hs_count;
    send(64'hDEAD_BEEF, 8'hFF);
    n = 0;
    while (hs_count - base < 2 && n < 50) begin
      @(posedge ap_clk);
      #1;
      n++;
    end
    check("pre_reset_beats", 128'(hs_count - base), 128'(2));
    areset = 1'b1;
    out_ready = 1'b0;
    @(posedge ap_clk);
    #1;
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_in_ready", 128'(in_ready), 128'(0));
    check("midrst_remaining", 128'(out_remaining), 128'(0));
    @(posedge ap_clk);
    #1;
    areset = 1'b0;
    out_ready = 1'b1;
    ready_mode = 0;
    base = hs_count;
    send(64'h4444, 8'h10);
    drain();
    check("post_reset_beats", 128'(hs_count - base), 128'(1));

    // Randomized payloads with a random consumer.
    ready_mode = 1;
    for (int it = 0; it < 60; it++) begin
      if (it % 10 == 0) begin
        drain();
        cfg_random();
      end
      m = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      send({$urandom, $urandom}, m);
      g = $urandom_range(0, 2);
      repeat (g) begin
        @(posedge ap_clk);
        #1;
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
